// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: response payload,
// legal read-latency range and the data value returned with an access fault.
package imem_pkg;

    localparam int IMEM_XLEN   = 32;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 4;

    localparam logic [IMEM_XLEN-1:0] FAULT_DATA = '0;

    typedef struct packed {
        logic [IMEM_XLEN-1:0] data;
        logic                 err;
    } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous show-ahead FIFO used to park responses while the consumer stalls.
// The head entry is visible on pop_data whenever empty is low.
module imem_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Credit accounting upstream guarantees these never fire.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full));
            assert (!(pop && empty));
        end
    end

    assign pop_data = mem[rd_ptr_reg[AW-1:0]];
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/imem_resp.sv
// Instruction-memory responder: fixed-latency word fetch with credit flow control
// and an in-order response FIFO. Define IMEM_ERR_CHECK_EN to flag misaligned/out-of-range fetches.
module imem_resp
    import imem_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h00000000,
    parameter int              LATENCY   = 1,
    parameter int              RSP_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [XLEN-1:0]          req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [XLEN-1:0]          rsp_data,
    output logic                     rsp_err,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [XLEN-1:0]          ld_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int PW = XLEN + 1;

    logic [XLEN-1:0] mem [DEPTH];
    logic [XLEN-1:0] ram_q_reg;
    logic            v1_reg;
    logic            err1_reg;
    logic [CW-1:0]   outst_reg;
    logic [CW-1:0]   outst_next;
    logic            req_ready_reg;
    logic            req_hs;
    logic            rsp_hs;
    logic            fault;
    logic            rd_en;
    logic [XLEN-1:0] off;
    logic [AW-1:0]   idx;
    logic [PW-1:0]   s1_pay;
    logic [PW-1:0]   fin_pay;
    logic [PW-1:0]   fifo_head;
    logic [PW-1:0]   sel_pay;
    logic            fin_v;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic            unused_bits;

    assign off = req_addr - BASE_ADDR;
    assign idx = off[AW+1:2];

`ifdef IMEM_ERR_CHECK_EN
    localparam logic [XLEN:0] LIMIT = (XLEN+1)'(DEPTH) << 2;
    // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
    assign fault = (req_addr[1:0] != 2'b00) || ({1'b0, off} >= LIMIT);
`else
    assign fault = 1'b0;
`endif

    assign unused_bits = ^{off[XLEN-1:AW+2], off[1:0], fifo_full};

    assign req_hs = req_valid && req_ready_reg;
    assign rd_en  = req_hs && !fault;

    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Read-before-write: a fetch colliding with a load sees the old word.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            ram_q_reg <= mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        assert (LATENCY >= LATENCY_MIN && LATENCY <= LATENCY_MAX);
        if (rst) begin
            v1_reg   <= 1'b0;
            err1_reg <= 1'b0;
        end else begin
            v1_reg   <= req_hs;
            err1_reg <= fault;
        end
    end

    assign s1_pay = {err1_reg, err1_reg ? XLEN'(FAULT_DATA) : ram_q_reg};

    generate
        if (LATENCY == 1) begin : g_lat1
            assign fin_v   = v1_reg;
            assign fin_pay = s1_pay;
        end else begin : g_latn
            for (genvar gi = 0; gi < LATENCY - 1; gi++) begin : g_stg
                logic          v_in;
                logic [PW-1:0] pay_in;
                logic          v_reg;
                logic [PW-1:0] pay_reg;
                if (gi == 0) begin : g_first
                    assign v_in   = v1_reg;
                    assign pay_in = s1_pay;
                end else begin : g_next
                    assign v_in   = g_stg[gi-1].v_reg;
                    assign pay_in = g_stg[gi-1].pay_reg;
                end
                always_ff @(posedge clk) begin
                    pay_reg <= pay_in;
                    if (rst) begin
                        v_reg <= 1'b0;
                    end else begin
                        v_reg <= v_in;
                    end
                end
            end
            assign fin_v   = g_stg[LATENCY-2].v_reg;
            assign fin_pay = g_stg[LATENCY-2].pay_reg;
        end
    endgenerate

    // Pipeline output bypasses the FIFO when it is empty and the consumer is ready.
    assign rsp_valid = !fifo_empty || fin_v;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign fifo_pop  = !fifo_empty && rsp_ready;
    assign fifo_push = fin_v && !(fifo_empty && rsp_ready);
    assign sel_pay   = fifo_empty ? fin_pay : fifo_head;
    assign rsp_data  = rsp_valid ? sel_pay[XLEN-1:0] : '0;
    assign rsp_err   = rsp_valid && sel_pay[XLEN];

    imem_rsp_fifo #(
        .WIDTH (PW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fin_pay),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        outst_next = outst_reg;
        if (req_hs && !rsp_hs) begin
            outst_next = outst_reg + 1'b1;
        end else if (!req_hs && rsp_hs) begin
            outst_next = outst_reg - 1'b1;
        end
    end

    // Ready is registered so it never depends combinationally on rsp_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            outst_reg     <= '0;
            req_ready_reg <= 1'b0;
        end else begin
            outst_reg     <= outst_next;
            req_ready_reg <= (outst_next < CW'(RSP_DEPTH));
        end
    end

    assign req_ready = req_ready_reg;

endmodule

// File: tb/tb_imem_resp.sv
// Directed bench for imem_resp: one LATENCY=1 instance and one LATENCY=3
// instance sharing clock, reset and load port.
module tb_imem_resp;
    import imem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_we;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_req_addr, a_rsp_data;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_addr, b_rsp_data;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] exp_mem [16];
    logic [31:0] s_addr  [16];
    imem_rsp_t   s_exp   [16];

    always #5 clk = ~clk;

    imem_resp #(
        .XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(1), .RSP_DEPTH(4)
    ) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
        .rsp_err(a_rsp_err),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    imem_resp #(
        .XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(3), .RSP_DEPTH(4)
    ) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .rsp_err(b_rsp_err),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        ld_we   = 1'b1;
        ld_addr = 10'(idx);
        ld_data = d;
        step();
        ld_we = 1'b0;
        exp_mem[idx] = d;
        $display("load word %0d = %h", idx, d);
    endtask

    task automatic fetch_a(input logic [31:0] addr, input logic [31:0] d,
                           input logic e, input string tag);
        check({tag, ".ready"}, a_req_ready, 1);
        a_req_valid = 1'b1;
        a_req_addr  = addr;
        a_rsp_ready = 1'b1;
        step();
        a_req_valid = 1'b0;
        check({tag, ".valid"}, a_rsp_valid, 1);
        check({tag, ".data"}, a_rsp_data, d);
        check({tag, ".err"}, a_rsp_err, e);
        $display("fetch %s addr=%h data=%h err=%b", tag, addr, a_rsp_data, a_rsp_err);
        step();
        check({tag, ".idle"}, a_rsp_valid, 0);
    endtask

    // Back-to-back requests from s_addr; response p-1 is expected one cycle after its handshake.
    task automatic stream_a(input int n, input string tag);
        a_rsp_ready = 1'b1;
        for (int p = 0; p <= n; p++) begin
            if (p > 0) begin
                check($sformatf("%s[%0d].valid", tag, p-1), a_rsp_valid, 1);
                check($sformatf("%s[%0d].data", tag, p-1), a_rsp_data, s_exp[p-1].data);
                check($sformatf("%s[%0d].err", tag, p-1), a_rsp_err, s_exp[p-1].err);
                $display("rsp %s[%0d] data=%h err=%b", tag, p-1, a_rsp_data, a_rsp_err);
            end else begin
                check($sformatf("%s.pre_valid", tag), a_rsp_valid, 0);
            end
            if (p < n) begin
                check($sformatf("%s[%0d].ready", tag, p), a_req_ready, 1);
                a_req_valid = 1'b1;
                a_req_addr  = s_addr[p];
            end else begin
                a_req_valid = 1'b0;
            end
            step();
        end
        check({tag, ".post_valid"}, a_rsp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        logic r;

        rst = 1'b1;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        a_req_valid = 1'b0; a_req_addr = '0; a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_addr = '0; b_rsp_ready = 1'b0;

        // Reset: load during reset, three reset edges.
        load(5, 32'h00500093);
        step();
        step();
        check("rst.a_ready", a_req_ready, 0);
        check("rst.b_ready", b_req_ready, 0);
        check("rst.a_valid", a_rsp_valid, 0);
        check("rst.a_data", a_rsp_data, 0);
        check("rst.a_err", a_rsp_err, 0);
        check("rst.b_valid", b_rsp_valid, 0);
        rst = 1'b0;
        step();
        check("rst.a_ready_after", a_req_ready, 1);
        check("rst.b_ready_after", b_req_ready, 1);
        fetch_a(32'h14, 32'h00500093, 1'b0, "boot5");

        for (int i = 0; i < 16; i++) begin
            if (i != 5) load(i, 32'hC0DE_0000 | 32'(i));
        end

        // Streaming 16 words.
        for (int i = 0; i < 16; i++) begin
            s_addr[i]     = 32'(i * 4);
            s_exp[i].data = exp_mem[i];
            s_exp[i].err  = 1'b0;
        end
        stream_a(16, "stream");

        // Faulting addresses between good neighbours.
        s_addr[0] = 32'h4; s_addr[1] = 32'h2; s_addr[2] = 32'h1000; s_addr[3] = 32'h8;
        s_exp[0].data = exp_mem[1]; s_exp[0].err = 1'b0;
        s_exp[3].data = exp_mem[2]; s_exp[3].err = 1'b0;
`ifdef IMEM_ERR_CHECK_EN
        s_exp[1].data = 32'h0; s_exp[1].err = 1'b1;
        s_exp[2].data = 32'h0; s_exp[2].err = 1'b1;
`else
        s_exp[1].data = exp_mem[0]; s_exp[1].err = 1'b0;
        s_exp[2].data = exp_mem[0]; s_exp[2].err = 1'b0;
`endif
        stream_a(4, "fault");

        // Load/fetch collision on word 2.
        load(2, 32'hAAAA_AAAA);
        check("coll.ready", a_req_ready, 1);
        ld_we = 1'b1; ld_addr = 10'd2; ld_data = 32'h5555_5555;
        a_req_valid = 1'b1; a_req_addr = 32'h8; a_rsp_ready = 1'b1;
        step();
        ld_we = 1'b0;
        a_req_valid = 1'b0;
        exp_mem[2] = 32'h5555_5555;
        check("coll.valid", a_rsp_valid, 1);
        check("coll.old_data", a_rsp_data, 32'hAAAA_AAAA);
        $display("fetch coll_old data=%h", a_rsp_data);
        step();
        check("coll.idle", a_rsp_valid, 0);
        fetch_a(32'h8, 32'h5555_5555, 1'b0, "coll_new");

        // Back-pressure: exactly RSP_DEPTH requests accepted.
        a_rsp_ready = 1'b0;
        a_req_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            r = a_req_ready;
            a_req_addr = 32'h20 + 32'(acc * 4);
            step();
            if (r) acc++;
        end
        a_req_valid = 1'b0;
        check("bp.accepted", 64'(acc), 4);
        check("bp.ready_low", a_req_ready, 0);
        check("bp.valid", a_rsp_valid, 1);
        check("bp.head", a_rsp_data, exp_mem[8]);
        step();
        check("bp.hold", a_rsp_data, exp_mem[8]);
        check("bp.ready_still_low", a_req_ready, 0);
        a_rsp_ready = 1'b1;
        step();
        check("bp.ready_after_pop", a_req_ready, 1);
        for (int k = 1; k < 4; k++) begin
            check($sformatf("bp[%0d].valid", k), a_rsp_valid, 1);
            check($sformatf("bp[%0d].data", k), a_rsp_data, exp_mem[8+k]);
            $display("rsp bp[%0d] data=%h", k, a_rsp_data);
            step();
        end
        check("bp.drained", a_rsp_valid, 0);

        // LATENCY=3 single fetch.
        b_rsp_ready = 1'b1;
        check("lat3.ready", b_req_ready, 1);
        b_req_valid = 1'b1; b_req_addr = 32'h14;
        step();
        b_req_valid = 1'b0;
        check("lat3.c1", b_rsp_valid, 0);
        step();
        check("lat3.c2", b_rsp_valid, 0);
        step();
        check("lat3.c3", b_rsp_valid, 1);
        check("lat3.data", b_rsp_data, exp_mem[5]);
        $display("fetch lat3 data=%h", b_rsp_data);
        step();
        check("lat3.idle", b_rsp_valid, 0);

        // Reset with three requests in flight.
        b_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_req_valid = 1'b1; b_req_addr = 32'(i * 4);
            step();
        end
        b_req_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        check("mid.rst_valid", b_rsp_valid, 0);
        check("mid.rst_ready", b_req_ready, 0);
        rst = 1'b0;
        b_rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("mid.quiet[%0d]", c), b_rsp_valid, 0);
        end
        check("mid.ready", b_req_ready, 1);

        // Full credit window available again after reset.
        b_rsp_ready = 1'b0;
        b_req_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            r = b_req_ready;
            b_req_addr = 32'h30 + 32'(acc * 4);
            step();
            if (r) acc++;
        end
        b_req_valid = 1'b0;
        check("mid.accepted", 64'(acc), 4);
        check("mid.ready_low", b_req_ready, 0);
        b_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("mid[%0d].valid", k), b_rsp_valid, 1);
            check($sformatf("mid[%0d].data", k), b_rsp_data, exp_mem[12+k]);
            $display("rsp mid[%0d] data=%h", k, b_rsp_data);
            step();
        end
        check("mid.drained", b_rsp_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
